// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Holds the PC, issues one I-cache   |
// |               request at a time, pre-decodes JAL/branches (using the     |
// |               branch predictor for conditional branches) to pick the next |
// |               PC, and buffers fetched words in a FIFO for the decoder.   |
// |               A ROB flush empties the queue and redirects the PC.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  output logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_pred_taken,
  input  logic        dec_ready
);

  localparam int AW = $clog2(IQ_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   stale_addr;
  logic [31:0]   stale_nxt;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW:0]   count_after;
  logic          push;
  logic          pop;

  logic [31:0]   q_inst  [IQ_DEPTH];
  logic [31:0]   q_pc    [IQ_DEPTH];
  logic          q_taken [IQ_DEPTH];

  logic [6:0]    opcode;
  logic [31:0]   j_imm;
  logic [31:0]   b_imm;
  logic [31:0]   npc;
  logic          ntaken;

  // While a flush is pending the stale request keeps its own address so the
  // cache sees a stable request even though pc already holds the redirect.
  assign ic_req_valid   = (state != S_IDLE);
  assign ic_req_addr    = (state == S_DISCARD) ? stale_addr : pc;
  assign pred_pc        = pc;

  assign dec_valid      = (count != '0);
  assign dec_inst       = q_inst[head];
  assign dec_pc         = q_pc[head];
  assign dec_pred_taken = q_taken[head];

  // A flush kills the pop along with everything else in that cycle.
  assign pop         = dec_valid & dec_ready & ~rob_flush;
  assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  // Pre-decode the returned word to choose the next PC and predicted-taken bit.
  always_comb begin
    opcode = ic_resp_inst[6:0];
    j_imm  = {{12{ic_resp_inst[31]}}, ic_resp_inst[19:12], ic_resp_inst[20],
              ic_resp_inst[30:21], 1'b0};
    b_imm  = {{20{ic_resp_inst[31]}}, ic_resp_inst[7], ic_resp_inst[30:25],
              ic_resp_inst[11:8], 1'b0};
    npc    = pc + 32'd4;
    ntaken = 1'b0;
    case (opcode)
      7'b1101111: begin
        npc    = pc + j_imm;
        ntaken = 1'b1;
      end
      7'b1100011: begin
        if (pred_taken) begin
          npc = pc + b_imm;
        end
        ntaken = pred_taken;
      end
      default: begin
        npc    = pc + 32'd4;
        ntaken = 1'b0;
      end
    endcase
  end

  // Next state, next PC and push decision; flush overrides normal fetch flow.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    stale_nxt = stale_addr;
    push      = 1'b0;
    if (rob_flush) begin
      pc_nxt = rob_flush_pc;
      case (state)
        S_WAIT: begin
          if (ic_resp_valid) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DISCARD;
            stale_nxt = pc;
          end
        end
        S_DISCARD: begin
          if (ic_resp_valid) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (count < CW'(IQ_DEPTH)) begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            push      = 1'b1;
            pc_nxt    = npc;
            state_nxt = (count_after < (CW+1)'(IQ_DEPTH)) ? S_WAIT : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (ic_resp_valid) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state register; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // PC and stale-request address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
    end else if (rdy) begin
      pc         <= pc_nxt;
      stale_addr <= stale_nxt;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at IQ_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (rob_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + AW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage write; contents need no reset since dec_valid qualifies them.
  always_ff @(posedge clk) begin
    if (rdy && push) begin
      q_inst[tail]  <= ic_resp_inst;
      q_pc[tail]    <= pc;
      q_taken[tail] <= ntaken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit: a behavioural cache and  |
// |               predictor drive the DUT while a transaction-level model of   |
// |               the fetch stream and instruction queue predicts its outputs. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, rdy, ic_req_valid, ic_resp_valid, pred_taken, rob_flush;
  logic        dec_valid, dec_pred_taken, dec_ready;
  logic [31:0] ic_req_addr, ic_resp_inst, pred_pc, rob_flush_pc, dec_inst, dec_pc;

  always #5 clk = ~clk;

  fetch_unit #(.IQ_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken), .dec_ready(dec_ready)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        tk;
  } ent_t;

  // Program image (aliased every 256 bytes) and its intended control flow.
  logic [31:0] mem_inst [64];
  int          mem_kind [64];   // 0 plain, 1 jal, 2 conditional branch
  int          mem_off  [64];
  logic        pred_tab [128];

  // Reference model state.
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_stale;
  logic [31:0] req_log[$];

  // Cache model state and stimulus knobs.
  bit          c_pend;
  logic [31:0] c_addr;
  int          c_delay;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  bit          rdy_val = 1'b1, flush_now = 1'b0;
  logic [31:0] flush_target = 32'h0;
  int          streak = 0;
  bit          last_rdy = 1'b0, last_flush = 1'b0;

  int          errors = 0, checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_plain(input int sel, input logic [31:0] r);
    logic [6:0] op;
    case (sel)
      0:       op = 7'b0010011;
      1:       op = 7'b0110011;
      2:       op = 7'b0000011;
      default: op = 7'b1100111;
    endcase
    return {r[31:7], op};
  endfunction

  // Architectural next fetch address for the word at a.
  function automatic logic [31:0] model_next(input logic [31:0] a, output logic tk);
    int idx;
    idx = int'(a[7:2]);
    tk  = 1'b0;
    case (mem_kind[idx])
      1: begin
        tk = 1'b1;
        return a + 32'(mem_off[idx]);
      end
      2: begin
        tk = pred_tab[a[8:2]];
        return tk ? a + 32'(mem_off[idx]) : a + 32'd4;
      end
      default: return a + 32'd4;
    endcase
  endfunction

  task automatic rand_program();
    int k;
    for (int i = 0; i < 64; i++) begin
      k = int'($urandom_range(0, 3));
      mem_off[i] = (int'($urandom_range(0, 16)) - 8) * 4;
      if (k == 2) begin
        mem_kind[i] = 1;
        mem_inst[i] = enc_jal(mem_off[i]);
      end else if (k == 3) begin
        mem_kind[i] = 2;
        mem_inst[i] = enc_br(mem_off[i]);
      end else begin
        mem_kind[i] = 0;
        mem_inst[i] = enc_plain(int'($urandom_range(0, 3)), $urandom);
      end
    end
    for (int i = 0; i < 128; i++) pred_tab[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; ic_resp_valid = 1'b0; ic_resp_inst = 32'h0;
    pred_taken = 1'b0; rob_flush = 1'b0; rob_flush_pc = 32'h0; dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_valid", ic_req_valid, 0);
    check_eq("rst_dec_valid", dec_valid, 0);
    rst = 1'b0;
    mq.delete(); req_log.delete();
    m_pc = RST_PC; m_stale = 1'b0; c_pend = 1'b0;
    streak = 0; last_rdy = 1'b0; last_flush = 1'b0;
  endtask

  // One clock: check outputs, run the cache, drive inputs, advance the model.
  task automatic cycle();
    logic [31:0] nxt;
    logic        tk;
    ent_t        e;
    @(negedge clk);
    check_eq("dec_valid", dec_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("dec_pc", dec_pc, mq[0].pc);
      check_eq("dec_inst", dec_inst, mq[0].inst);
      check_eq("dec_pred_taken", dec_pred_taken, mq[0].tk);
    end
    if (mq.size() == DEPTH) check_eq("idle_when_full", ic_req_valid, 0);
    if (c_pend) begin
      check_eq("req_held", ic_req_valid, 1);
      check_eq("req_addr_stable", ic_req_addr, c_addr);
    end else if (ic_req_valid) begin
      c_pend  = 1'b1;
      c_addr  = ic_req_addr;
      c_delay = int'($urandom_range(lat_min, lat_max));
      req_log.push_back(ic_req_addr);
      check_eq("req_addr", ic_req_addr, m_pc);
    end
    if (last_flush || ic_req_valid) begin
      streak = 0;
    end else if (last_rdy && mq.size() < DEPTH) begin
      streak++;
      if (streak > 2) check_eq("issue_timeout", ic_req_valid, 1);
    end

    rdy           = rdy_val;
    rob_flush     = flush_now;
    rob_flush_pc  = flush_now ? flush_target : $urandom;
    dec_ready     = (int'($urandom_range(0, 99)) < ready_pct);
    ic_resp_valid = c_pend && (c_delay == 0);
    ic_resp_inst  = ic_resp_valid ? mem_inst[c_addr[7:2]] : $urandom;
    pred_taken    = pred_tab[pred_pc[8:2]];

    if (rdy) begin
      if (ic_resp_valid && !m_stale) check_eq("pred_pc", pred_pc, c_addr);
      if (rob_flush) begin
        mq.delete();
        m_pc    = rob_flush_pc;
        m_stale = c_pend && !ic_resp_valid;
      end else begin
        if (mq.size() != 0 && dec_ready) void'(mq.pop_front());
        if (ic_resp_valid) begin
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            nxt    = model_next(c_addr, tk);
            e.inst = mem_inst[c_addr[7:2]];
            e.pc   = c_addr;
            e.tk   = tk;
            mq.push_back(e);
            m_pc   = nxt;
          end
        end
      end
      if (ic_resp_valid) c_pend = 1'b0;
    end
    if (c_pend && c_delay > 0) c_delay--;
    last_rdy   = rdy;
    last_flush = rob_flush && rdy;
    flush_now  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_seq [9];
    int          n;
    bit          found;

    rst = 1'b1; rdy = 1'b1; ic_resp_valid = 1'b0; ic_resp_inst = 32'h0;
    pred_taken = 1'b0; rob_flush = 1'b0; rob_flush_pc = 32'h0; dec_ready = 1'b0;

    // Directed program: straight-line addi, JAL +8 at 0x10, BEQ -16 at 0x20.
    for (int i = 0; i < 64; i++) begin
      mem_inst[i] = enc_plain(0, $urandom);
      mem_kind[i] = 0;
      mem_off[i]  = 0;
    end
    for (int i = 0; i < 128; i++) pred_tab[i] = 1'b0;
    mem_inst[4] = 32'h008000EF; mem_kind[4] = 1; mem_off[4] = 8;
    mem_inst[8] = enc_br(-16);  mem_kind[8] = 2; mem_off[8] = -16;
    pred_tab[8] = 1'b1;

    exp_seq[0] = 32'h00; exp_seq[1] = 32'h04; exp_seq[2] = 32'h08;
    exp_seq[3] = 32'h0C; exp_seq[4] = 32'h10; exp_seq[5] = 32'h18;
    exp_seq[6] = 32'h1C; exp_seq[7] = 32'h20; exp_seq[8] = 32'h10;

    do_reset();
    cycle();
    check_eq("first_req_count", req_log.size(), 1);
    repeat (24) cycle();
    check_eq("seq_len", (req_log.size() >= 9), 1);
    for (int i = 0; i < 9; i++) begin
      if (i < req_log.size()) check_eq("seq_addr", req_log[i], exp_seq[i]);
    end

    // Branch at 0x20 predicted not taken falls through to 0x24.
    pred_tab[8] = 1'b0;
    repeat (4) cycle();
    req_log.delete();
    repeat (24) cycle();
    found = 1'b0;
    for (int i = 0; i + 1 < req_log.size(); i++) begin
      if (!found && req_log[i] == 32'h20) begin
        check_eq("beq_not_taken", req_log[i+1], 32'h24);
        found = 1'b1;
      end
    end
    check_eq("beq_seen", found, 1);

    // Decoder stalled: exactly DEPTH fetches, then one pop allows one more.
    do_reset();
    ready_pct = 0;
    repeat (40) cycle();
    check_eq("full_reqs", req_log.size(), DEPTH);
    check_eq("full_idle", ic_req_valid, 0);
    ready_pct = 100;
    cycle();
    ready_pct = 0;
    repeat (20) cycle();
    check_eq("one_more_req", req_log.size(), DEPTH + 1);
    check_eq("refill_idle", ic_req_valid, 0);

    // Flush to 0x100 while waiting; stale response comes 3 cycles later.
    do_reset();
    ready_pct = 100; lat_min = 4; lat_max = 4;
    for (int k = 0; k < 20 && !c_pend; k++) cycle();
    check_eq("wait_req", c_pend, 1);
    n = req_log.size();
    flush_target = 32'h100;
    flush_now    = 1'b1;
    cycle();
    cycle();
    check_eq("flush_dec_valid", dec_valid, 0);
    repeat (12) cycle();
    check_eq("flush_new_req", (req_log.size() > n), 1);
    if (req_log.size() > n) check_eq("flush_target", req_log[n], 32'h100);

    // rdy low for 5 cycles in the middle of a request.
    for (int k = 0; k < 20 && !c_pend; k++) cycle();
    check_eq("wait_req2", c_pend, 1);
    rdy_val = 1'b0;
    repeat (5) cycle();
    rdy_val = 1'b1;
    repeat (20) cycle();

    // Randomized traffic: alternating decoder pressure, stalls, flushes, resets.
    rand_program();
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int seg = 0; seg < 10; seg++) begin
      ready_pct = (seg % 2 == 0) ? 15 : 80;
      for (int k = 0; k < 300; k++) begin
        rdy_val = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 39) == 0) begin
          flush_now    = 1'b1;
          flush_target = $urandom & 32'hFFFF_FFFC;
        end
        if ($urandom_range(0, 499) == 0) begin
          flush_now = 1'b0;
          do_reset();
        end else begin
          cycle();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
